load_store_queue: RTL and testbench
===================================

Name: load_store_queue

Overview:
- Memory-side end of the execute-stage load/store queue interface. It accepts load and store entries written by the execute stage and buffers them in a single in-order FIFO, so program order between loads and stores is kept.
- Issues each entry to the data-memory port one at a time and returns load results, sign- or zero-extended, to a dedicated register-file write port.
- Flags misaligned or illegal accesses to the hart vectoring controller.

Parameters:
- C_XLEN, 32, data/address width (package constant, not overridable per instance).
- P_DEPTH, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous reset, active high
- clk_en_i  in  1  global clock enable; when low, all state holds
- ex_lq_full_o  out  1  queue full; the execute stage must not write while it is high
- ex_lq_wr_i  in  1  push a load entry
- ex_sq_wr_i  in  1  push a store entry
- ex_funct3_i  in  3  access size/sign (RV32I encoding)
- ex_regd_addr_i  in  5  load destination register
- ex_regs2_data_i  in  C_XLEN  store data
- ex_addr_i  in  C_XLEN  byte address
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  C_XLEN  word-aligned address ({addr[31:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  C_XLEN  lane-replicated store data
- dmem_ack_i  in  1  request accepted/completed; read data valid in the same cycle
- dmem_rdata_i  in  C_XLEN  read word
- regd_wr_o  out  1  load write-back strobe
- regd_addr_o  out  5  write-back register
- regd_data_o  out  C_XLEN  extended load data
- hvec_fault_o  out  1  one-cycle fault strobe
- hvec_fault_addr_o  out  C_XLEN  faulting byte address
- empty_o  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset values: all outputs 0 except empty_o=1; FIFO pointers and count 0; FSM in IDLE.
- Gating: every register updates only when clk_en_i=1. Strobes that are high are held, not repeated, while clk_en_i=0.
- FIFO:
  - Entry = {is_store, funct3, regd_addr, data, addr}.
  - Push when (ex_lq_wr_i|ex_sq_wr_i) and not full. Both push inputs high = store wins (illegal usage; no fault raised).
  - A push while full is dropped, even if a pop happens in the same cycle.
  - ex_lq_full_o = (count==P_DEPTH), registered-state derived, no combinational path from the inputs.
  - Pointers wrap modulo P_DEPTH. Count is log2(P_DEPTH)+1 bits.
  - Simultaneous push and pop with count at neither bound leaves count unchanged.
- FSM states: IDLE, REQ, WB.
  - IDLE with FIFO non-empty: check the head entry.
  - Illegal head: funct3 is 011, 110 or 111; or a store with funct3 of 100 or 101; or misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0).
    - Pop the entry.
    - Pulse hvec_fault_o for 1 cycle with hvec_fault_addr_o=addr.
    - Stay in IDLE.
  - Legal head: go to REQ on the next edge, driving the dmem_* outputs from the head.
  - REQ:
    - dmem_req_o=1 and all dmem_* outputs stable until dmem_ack_i.
    - On ack, pop. A store returns to IDLE. A load captures the extended data into the write-back register and goes to WB.
  - WB: regd_wr_o=1 for exactly 1 cycle, then IDLE.
  - Minimum occupancy per legal access: 2 cycles for a store with zero-wait ack, 3 cycles for a load.
- Byte lanes:
  - SB: be=1<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{data[15:0]}}.
  - SW: be=1111, wdata=data.
- Load extraction: select the byte or halfword by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW takes the word as is.
- Loads to x0: the memory access is still performed; regd_wr_o still pulses with regd_addr_o=0 (the register file ignores x0).
- Reset asserted mid-access aborts it immediately: dmem_req_o drops and the FIFO contents are discarded.

Decomposition:
- Shared package: C_XLEN; funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101); FSM enum t_lsq_state {IDLE, REQ, WB}; entry struct type.
- Sub-module lsq_fifo: parameterised synchronous FIFO with push/pop/head/full/empty/count.

Test Plan:
1. SW addr=0x100 data=0xDEADBEEF, ack 1 cycle after req -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; empty_o returns to 1.
2. LB addr=0x203, rdata=0x80FF_FF7F -> regd_data=0xFFFFFF80, single regd_wr pulse. Same access as LBU -> 0x00000080.
3. SH addr=0x12 data=0x0000ABCD -> be=1100, wdata=0xABCDABCD. LHU addr=0x12 with rdata=0xABCD0000 -> 0x0000ABCD.
4. LW addr=0x101 -> hvec_fault_o 1 cycle, fault_addr=0x101, no dmem_req, no regd_wr.
5. Hold dmem_ack_i low and push P_DEPTH+1 entries -> full after 4 pushes, 5th dropped; release ack -> exactly 4 accesses in push order.
6. Assert reset_i while dmem_req_o=1 -> req=0 in the same cycle; after release empty_o=1 and no write-back. Separately, clk_en_i=0 during WB -> regd_wr held, single write on re-enable.

Source files
------------

// File: rtl/load_store_queue_pkg.sv
// Purpose: shared types, funct3 codes and lane helpers for the load/store queue.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package load_store_queue_pkg;

  localparam int C_XLEN = 32;

  // RV32I load/store size and sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } t_lsq_state;

  typedef struct packed {
    logic              is_store;
    logic [2:0]        funct3;
    logic [4:0]        regd_addr;
    logic [C_XLEN-1:0] data;
    logic [C_XLEN-1:0] addr;
  } t_lsq_entry;

  // Unknown size codes, unsigned stores and misaligned halfword/word accesses
  // never reach memory.
  function automatic logic lsq_illegal(input t_lsq_entry e);
    logic bad_code;
    logic misaligned;
    bad_code   = (e.funct3 == 3'b011) || (e.funct3 == 3'b110) || (e.funct3 == 3'b111) ||
                 (e.is_store && ((e.funct3 == F3_BU) || (e.funct3 == F3_HU)));
    misaligned = ((e.funct3 == F3_H) || (e.funct3 == F3_HU)) ? e.addr[0] :
                 (e.funct3 == F3_W) ? (e.addr[1:0] != 2'b00) : 1'b0;
    return bad_code || misaligned;
  endfunction

  // Byte enables follow the access size; bit 2 of funct3 (unsigned) does not
  // change which lanes are touched.
  function automatic logic [3:0] lsq_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across every lane so the byte enables alone
  // decide which bytes land.
  function automatic logic [C_XLEN-1:0] lsq_wdata(input logic [2:0] f3,
                                                   input logic [C_XLEN-1:0] d);
    logic [C_XLEN-1:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed byte/halfword out of the read word and extend it.
  function automatic logic [C_XLEN-1:0] lsq_load_ext(input logic [2:0] f3,
                                                      input logic [1:0] a,
                                                      input logic [C_XLEN-1:0] w);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [C_XLEN-1:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_queue_fifo.sv
// Purpose: generic synchronous FIFO with head peek, full/empty and occupancy.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
module lsq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// Purpose: in-order load/store queue issuing to the data-memory port, with load write-back and fault flagging.
// Latency: store >= 2 cycles, load >= 3 cycles from reaching head; faults strobe the cycle after the head is checked.
// Backpressure: ex_lq_full_o blocks the execute stage; dmem_ack_i stalls the head in REQ indefinitely.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int P_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_i,
  output logic              ex_lq_full_o,
  input  logic              ex_lq_wr_i,
  input  logic              ex_sq_wr_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [4:0]        ex_regd_addr_i,
  input  logic [C_XLEN-1:0] ex_regs2_data_i,
  input  logic [C_XLEN-1:0] ex_addr_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [C_XLEN-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [C_XLEN-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [C_XLEN-1:0] dmem_rdata_i,
  output logic              regd_wr_o,
  output logic [4:0]        regd_addr_o,
  output logic [C_XLEN-1:0] regd_data_o,
  output logic              hvec_fault_o,
  output logic [C_XLEN-1:0] hvec_fault_addr_o,
  output logic              empty_o
);

  localparam int C_CNT_W = $clog2(P_DEPTH) + 1;

  t_lsq_state         state_q;
  t_lsq_state         state_d;
  t_lsq_entry         push_entry;
  t_lsq_entry         head;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [C_CNT_W-1:0] fifo_count;
  logic               head_illegal;
  logic               pop_req;
  logic               fault_set;
  logic               wb_capture;
  logic               fault_q;
  logic [C_XLEN-1:0]  fault_addr_q;
  logic [4:0]         regd_addr_q;
  logic [C_XLEN-1:0]  regd_data_q;

  // A store wins when both push strobes are raised together.
  always_comb begin
    push_entry           = '0;
    push_entry.is_store  = ex_sq_wr_i;
    push_entry.funct3    = ex_funct3_i;
    push_entry.regd_addr = ex_regd_addr_i;
    push_entry.data      = ex_regs2_data_i;
    push_entry.addr      = ex_addr_i;
  end

  assign fifo_push    = clk_en_i && (ex_lq_wr_i || ex_sq_wr_i) && !fifo_full;
  assign fifo_pop     = clk_en_i && pop_req;
  assign head_illegal = lsq_illegal(head);

  lsq_fifo #(
    .WIDTH ($bits(t_lsq_entry)),
    .DEPTH (P_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (fifo_push),
    .push_dat_i (push_entry),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // The full flag is purely registered state, so it has no path from the inputs.
  assign ex_lq_full_o = fifo_full;
  assign empty_o      = fifo_empty && (state_q == IDLE);
  assign regd_wr_o    = (state_q == WB);
  assign regd_addr_o  = regd_addr_q;
  assign regd_data_o  = regd_data_q;
  assign hvec_fault_o      = fault_q;
  assign hvec_fault_addr_o = fault_addr_q;

  // Full flag and occupancy must always agree.
  assert property (@(posedge clk_i) disable iff (reset_i)
                   fifo_full == (fifo_count == C_CNT_W'(P_DEPTH)));

  // FSM state register; holds while the clock enable is low.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  // Next-state: legal heads go to REQ, faulting heads are dropped in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !head_illegal) state_d = REQ;
      end
      REQ: begin
        if (dmem_ack_i) state_d = head.is_store ? IDLE : WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory port driven straight from the head so it is stable until ack.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    pop_req      = 1'b0;
    fault_set    = 1'b0;
    wb_capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && head_illegal) begin
          fault_set = 1'b1;
          pop_req   = 1'b1;
        end
      end
      REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = head.is_store;
        dmem_addr_o  = {head.addr[C_XLEN-1:2], 2'b00};
        dmem_be_o    = lsq_be(head.funct3, head.addr[1:0]);
        dmem_wdata_o = head.is_store ? lsq_wdata(head.funct3, head.data) : '0;
        if (dmem_ack_i) begin
          pop_req    = 1'b1;
          wb_capture = !head.is_store;
        end
      end
      default: ;
    endcase
  end

  // Fault strobe and write-back registers; all hold while the clock enable is low.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      regd_addr_q  <= '0;
      regd_data_q  <= '0;
    end else if (clk_en_i) begin
      fault_q <= fault_set;
      if (fault_set) fault_addr_q <= head.addr;
      if (wb_capture) begin
        regd_addr_q <= head.regd_addr;
        regd_data_q <= lsq_load_ext(head.funct3, head.addr[1:0], dmem_rdata_i);
      end
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
module tb_load_store_queue;
  import load_store_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        clk_en_i = 1'b1;
  logic        ex_lq_full_o;
  logic        ex_lq_wr_i = 1'b0;
  logic        ex_sq_wr_i = 1'b0;
  logic [2:0]  ex_funct3_i = '0;
  logic [4:0]  ex_regd_addr_i = '0;
  logic [31:0] ex_regs2_data_i = '0;
  logic [31:0] ex_addr_i = '0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        regd_wr_o;
  logic [4:0]  regd_addr_o;
  logic [31:0] regd_data_o;
  logic        hvec_fault_o;
  logic [31:0] hvec_fault_addr_o;
  logic        empty_o;

  load_store_queue #(.P_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .ex_lq_full_o(ex_lq_full_o), .ex_lq_wr_i(ex_lq_wr_i), .ex_sq_wr_i(ex_sq_wr_i),
    .ex_funct3_i(ex_funct3_i), .ex_regd_addr_i(ex_regd_addr_i),
    .ex_regs2_data_i(ex_regs2_data_i), .ex_addr_i(ex_addr_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .regd_wr_o(regd_wr_o), .regd_addr_o(regd_addr_o),
    .regd_data_o(regd_data_o), .hvec_fault_o(hvec_fault_o),
    .hvec_fault_addr_o(hvec_fault_addr_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } acc_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  acc_t        exp_acc[$];
  wb_t         exp_wb[$];
  logic [31:0] exp_flt[$];
  bit [31:0]   mem [bit [31:0]];

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int ack_mode = 1;   // 0: never ack, 1: ack on 2nd req cycle, 2: ack on 1st req cycle
  int req_age = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string s);
    n_vec++;
    n_err++;
    $display("FAIL %s", s);
  endtask

  // ---------------- reference model: rules of the RV32 access, not the RTL ---
  function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (st && f3 >= 3'd4) return 1'b0;
    sz = 1 << (f3 & 3'd3);
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, mask, v;
    int          sh;
    w  = model_word(a & ~32'd3);
    sh = 8 * int'(a % 4);
    if ((f3 & 3'd3) == 3'd2) return w;
    mask = ((f3 & 3'd3) == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    v    = (w >> sh) & mask;
    if (f3 < 3'd4 && ((v & ((mask + 32'd1) >> 1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3 & 3'd3)
      3'd0:    return 4'(1 << (a % 4));
      3'd1:    return ((a % 4) == 0) ? 4'h3 : 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3 & 3'd3)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Drive one entry for one clock; exp_full is the hand-computed queue state.
  task automatic push(input bit st, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] d, input logic [31:0] a, input bit exp_full);
    acc_t e;
    wb_t  w;
    chk("ex_lq_full_o", {31'd0, ex_lq_full_o}, {31'd0, exp_full});
    ex_sq_wr_i      = st;
    ex_lq_wr_i      = !st;
    ex_funct3_i     = f3;
    ex_regd_addr_i  = rd;
    ex_regs2_data_i = d;
    ex_addr_i       = a;
    if (!exp_full) begin
      if (model_legal(st, f3, a)) begin
        e.addr  = a & ~32'd3;
        e.be    = model_be(f3, a);
        e.wdata = model_wdata(f3, d);
        e.we    = st;
        exp_acc.push_back(e);
        if (!st) begin
          w.rd   = rd;
          w.data = model_load(f3, a);
          exp_wb.push_back(w);
        end
      end else begin
        exp_flt.push_back(a);
      end
    end
    @(posedge clk_i); #1;
    ex_sq_wr_i = 1'b0;
    ex_lq_wr_i = 1'b0;
  endtask

  task automatic wait_for(input int which, input string nm);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge clk_i); #1;
      case (which)
        0:       hit = dmem_req_o;
        1:       hit = regd_wr_o;
        2:       hit = hvec_fault_o;
        default: hit = empty_o;
      endcase
    end
    if (!hit) fail_msg($sformatf("timeout_%s: event not seen within 100 cycles, required it", nm));
  endtask

  task automatic wait_idle();
    wait_for(3, "empty");
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  // Memory responder and per-cycle compare against the model's event queues.
  initial begin
    acc_t e;
    wb_t  w;
    logic [31:0] fa;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        req_age    = 0;
        dmem_ack_i = 1'b0;
      end else begin
        req_age      = dmem_req_o ? req_age + 1 : 0;
        dmem_ack_i   = dmem_req_o && (ack_mode == 2 || (ack_mode == 1 && req_age >= 2));
        dmem_rdata_i = model_word(dmem_addr_o);
        if (clk_en_i) begin
          if (dmem_req_o && dmem_ack_i) begin
            n_acc++;
            if (exp_acc.size() == 0) begin
              fail_msg($sformatf("acc_unexpected: got access at 0x%08h, required none", dmem_addr_o));
            end else begin
              e = exp_acc.pop_front();
              chk("acc_addr", dmem_addr_o, e.addr);
              chk("acc_we", {31'd0, dmem_we_o}, {31'd0, e.we});
              chk("acc_be", {28'd0, dmem_be_o}, {28'd0, e.be});
              if (e.we) chk("acc_wdata", dmem_wdata_o, e.wdata);
            end
          end
          if (regd_wr_o) begin
            if (exp_wb.size() == 0) begin
              fail_msg($sformatf("wb_unexpected: got write x%0d=0x%08h, required none", regd_addr_o, regd_data_o));
            end else begin
              w = exp_wb.pop_front();
              chk("wb_addr", {27'd0, regd_addr_o}, {27'd0, w.rd});
              chk("wb_data", regd_data_o, w.data);
            end
          end
          if (hvec_fault_o) begin
            if (exp_flt.size() == 0) begin
              fail_msg($sformatf("fault_unexpected: got fault at 0x%08h, required none", hvec_fault_addr_o));
            end else begin
              fa = exp_flt.pop_front();
              chk("fault_addr", hvec_fault_addr_o, fa);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_before;
    mem[32'h0000_0200] = 32'h80FF_FF7F;
    mem[32'h0000_0010] = 32'hABCD_0000;
    mem[32'h0000_0300] = 32'h1234_8765;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_full", {31'd0, ex_lq_full_o}, 32'd0);
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_regd_wr", {31'd0, regd_wr_o}, 32'd0);
    chk("rst_fault", {31'd0, hvec_fault_o}, 32'd0);
    chk("rst_regd_data", regd_data_o, 32'd0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    // 1: SW, ack one cycle after req
    push(1'b1, F3_W, 5'd0, 32'hDEAD_BEEF, 32'h100, 1'b0);
    wait_for(0, "sw_req");
    chk("sw_addr", dmem_addr_o, 32'h100);
    chk("sw_be", {28'd0, dmem_be_o}, 32'hF);
    chk("sw_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
    chk("sw_we", {31'd0, dmem_we_o}, 32'd1);
    wait_idle();
    chk("sw_empty", {31'd0, empty_o}, 32'd1);

    // 2: LB / LBU of the top byte
    push(1'b0, F3_B, 5'd5, 32'd0, 32'h203, 1'b0);
    wait_for(1, "lb_wb");
    chk("lb_data", regd_data_o, 32'hFFFF_FF80);
    chk("lb_rd", {27'd0, regd_addr_o}, 32'd5);
    @(posedge clk_i); #1;
    chk("lb_single_pulse", {31'd0, regd_wr_o}, 32'd0);
    push(1'b0, F3_BU, 5'd6, 32'd0, 32'h203, 1'b0);
    wait_for(1, "lbu_wb");
    chk("lbu_data", regd_data_o, 32'h0000_0080);
    wait_idle();

    // 3: halfword lanes, then zero-wait acks
    push(1'b1, F3_H, 5'd0, 32'h0000_ABCD, 32'h12, 1'b0);
    wait_for(0, "sh_req");
    chk("sh_addr", dmem_addr_o, 32'h10);
    chk("sh_be", {28'd0, dmem_be_o}, 32'hC);
    chk("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
    wait_idle();
    push(1'b0, F3_HU, 5'd7, 32'd0, 32'h12, 1'b0);
    wait_for(1, "lhu_wb");
    chk("lhu_data", regd_data_o, 32'h0000_ABCD);
    wait_idle();
    ack_mode = 2;
    push(1'b1, F3_B, 5'd0, 32'h0000_005A, 32'h302, 1'b0);
    wait_for(0, "sb_req");
    chk("sb_be", {28'd0, dmem_be_o}, 32'h4);
    chk("sb_wdata", dmem_wdata_o, 32'h5A5A_5A5A);
    wait_idle();
    push(1'b0, F3_H, 5'd8, 32'd0, 32'h300, 1'b0);
    wait_for(1, "lh_wb");
    chk("lh_data", regd_data_o, 32'hFFFF_8765);
    push(1'b0, F3_W, 5'd0, 32'd0, 32'h300, 1'b0);
    wait_for(1, "x0_wb");
    chk("x0_rd", {27'd0, regd_addr_o}, 32'd0);
    chk("x0_data", regd_data_o, 32'h1234_8765);
    wait_idle();
    ack_mode = 1;

    // 4: misaligned / illegal entries fault without touching memory
    push(1'b0, F3_W, 5'd4, 32'd0, 32'h101, 1'b0);
    wait_for(2, "lw_fault");
    chk("lw_fault_addr", hvec_fault_addr_o, 32'h101);
    chk("lw_fault_req", {31'd0, dmem_req_o}, 32'd0);
    @(posedge clk_i); #1;
    chk("lw_fault_single", {31'd0, hvec_fault_o}, 32'd0);
    push(1'b1, F3_BU, 5'd0, 32'h11, 32'h40, 1'b0);
    push(1'b0, 3'b011, 5'd2, 32'd0, 32'h44, 1'b0);
    push(1'b1, F3_B, 5'd0, 32'h77, 32'h45, 1'b0);
    push(1'b0, F3_H, 5'd3, 32'd0, 32'h47, 1'b0);
    push(1'b1, F3_W, 5'd0, 32'h99, 32'h102, 1'b0);
    wait_idle();

    // 5: fill the queue with ack held off; the fifth push is dropped
    ack_mode = 0;
    for (int i = 0; i < DEPTH; i++)
      push(1'b1, F3_W, 5'd0, 32'hA000_0000 + i, 32'h400 + 4 * i, 1'b0);
    push(1'b1, F3_W, 5'd0, 32'hBAD0_0000, 32'h410, 1'b1);
    chk("full_held", {31'd0, ex_lq_full_o}, 32'd1);
    acc_before = n_acc;
    ack_mode = 1;
    wait_idle();
    chk("full_access_count", n_acc - acc_before, DEPTH);

    // 6a: reset during an outstanding request
    ack_mode = 0;
    push(1'b0, F3_W, 5'd9, 32'd0, 32'h200, 1'b0);
    wait_for(0, "rst_req");
    reset_i = 1'b1;
    #1;
    chk("rst_abort_req", {31'd0, dmem_req_o}, 32'd0);
    exp_acc.delete();
    exp_wb.delete();
    exp_flt.delete();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    ack_mode = 1;
    #1;
    chk("rst_abort_empty", {31'd0, empty_o}, 32'd1);
    repeat (6) @(posedge clk_i);
    #1;
    chk("rst_abort_no_wb", {31'd0, regd_wr_o}, 32'd0);

    // 6b: clock enable dropped during write-back holds the strobe
    ack_mode = 2;
    push(1'b0, F3_W, 5'd3, 32'd0, 32'h200, 1'b0);
    wait_for(1, "cke_wb");
    clk_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("cke_wb_held", {31'd0, regd_wr_o}, 32'd1);
    end
    chk("cke_wb_data", regd_data_o, 32'h80FF_FF7F);
    clk_en_i = 1'b1;
    @(posedge clk_i); #1;
    chk("cke_wb_released", {31'd0, regd_wr_o}, 32'd0);
    wait_idle();

    chk("acc_drained", exp_acc.size(), 32'd0);
    chk("wb_drained", exp_wb.size(), 32'd0);
    chk("fault_drained", exp_flt.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
